// File: rtl/module_counter_pkg.sv
// ---------------------------------------------------------------------------
// module_counter_pkg
// Shared definitions for the free-running prescaled counter.
//   COUNT_W         : width of the visible count value
//   count_t         : count value type
//   prescale_width  : prescaler register width for a given DIV,
//                     max(1, $clog2(DIV))
// No ports (package).
// ---------------------------------------------------------------------------
package module_counter_pkg;

  localparam int COUNT_W = 6;

  typedef logic [COUNT_W-1:0] count_t;

  // A DIV of 1 still needs a one-bit register, hence the floor of 1.
  function automatic int prescale_width(input int div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/module_counter_if.sv
// ---------------------------------------------------------------------------
// module_counter_if
// Observation bundle for the counter value. The counter itself exposes only
// clk, rst and count_o; this interface lets an environment carry the count
// around as one object.
//   count : current count value
// Modports:
//   master : drives count (the counter side)
//   slave  : observes count (the consumer side)
// ---------------------------------------------------------------------------
interface module_counter_if;
  import module_counter_pkg::*;

  count_t count;

  modport master (output count);
  modport slave  (input  count);

endinterface

// File: rtl/module_counter_prescaler.sv
// ---------------------------------------------------------------------------
// module_counter_prescaler
// Counts 0..DIV-1 on every rising clk edge and flags the terminal count.
// Parameters:
//   DIV    : cycles per tick (>= 1)
// Ports:
//   clk    : in  clock, rising edge
//   rst    : in  asynchronous active-high reset
//   tick_o : out high for the one cycle in which the prescaler sits at DIV-1
// Optional: MODULE_COUNTER_ASSERT_EN adds a range assertion on the prescaler.
// ---------------------------------------------------------------------------
module module_counter_prescaler
  import module_counter_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int PW = prescale_width(DIV);
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);

  logic [PW-1:0] pre;

  // Free-running modulo-DIV counter; reset discards any partial period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (pre == TERM) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // The tick is decoded from the register so the consumer advances on the
  // very edge where the prescaler wraps.
  assign tick_o = (pre == TERM);

`ifdef MODULE_COUNTER_ASSERT_EN
  a_pre_range: assert property (@(posedge clk) disable iff (rst) pre <= TERM)
    else $error("prescaler exceeded DIV-1");
`endif

endmodule

// File: rtl/module_counter.sv
// ---------------------------------------------------------------------------
// module_counter
// Six-bit free-running counter that advances once every DIV clock cycles and
// wraps 63 -> 0 silently. No enable, no load.
// Parameters:
//   DIV     : clock cycles per count step (>= 1, elaboration error otherwise)
// Ports:
//   clk     : in  clock, rising edge
//   rst     : in  asynchronous active-high reset (clears count and prescaler)
//   count_o : out current count, straight from a register
// Optional: MODULE_COUNTER_ASSERT_EN compiles embedded concurrent assertions.
// ---------------------------------------------------------------------------
module module_counter
  import module_counter_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic   clk,
  input  logic   rst,
  output count_t count_o
);

  if (DIV < 1) begin : g_div_check
    $error("module_counter: DIV must be at least 1");
  end

  logic tick;

  module_counter_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  // Count register: one step per prescaler tick, natural 6-bit wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_o <= '0;
    end else if (tick) begin
      count_o <= count_o + count_t'(1);
    end
  end

`ifdef MODULE_COUNTER_ASSERT_EN
  a_step_by_one: assert property (@(posedge clk) disable iff (rst)
      $changed(count_o) |-> (count_o == count_t'($past(count_o) + count_t'(1))))
    else $error("count_o changed by other than +1");

  a_step_on_tick: assert property (@(posedge clk) disable iff (rst)
      $changed(count_o) |-> $past(tick))
    else $error("count_o changed without a terminal-count tick");

  // This one has to look at reset itself, so it carries no disable clause.
  a_zero_in_reset: assert property (@(posedge clk) rst |-> (count_o == '0))
    else $error("count_o nonzero while reset is high");
`endif

endmodule

// File: tb/tb_module_counter.sv
// ---------------------------------------------------------------------------
// tb_module_counter
// Directed bench for module_counter: one DIV=10 instance and one DIV=1
// instance, each with its own reset, sharing a 20 ns clock.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_module_counter;
  import module_counter_pkg::*;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   errors;

  module_counter_if cif_a ();
  module_counter_if cif_b ();

  module_counter #(
    .DIV (10)
  ) dut_a (
    .clk     (clk),
    .rst     (rst_a),
    .count_o (cif_a.count)
  );

  module_counter #(
    .DIV (1)
  ) dut_b (
    .clk     (clk),
    .rst     (rst_b),
    .count_o (cif_b.count)
  );

  // 20 ns period, first rising edge at 10 ns.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    checks++;
    if (cif_a.count !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_t0_a: got %0d, expected 0", cif_a.count);
    end
    step(2);
    checks++;
    if (cif_a.count !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_hold_a: got %0d, expected 0", cif_a.count);
    end
    checks++;
    if (cif_b.count !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_hold_b: got %0d, expected 0", cif_b.count);
    end
    // Release away from the active edge, after more than 30 ns of reset.
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_first_increment();
    step(9);
    checks++;
    if (cif_a.count !== 6'd0) begin
      errors++;
      $display("[TB] FAIL first_edge9: got %0d, expected 0", cif_a.count);
    end
    step(1);
    checks++;
    if (cif_a.count !== 6'd1) begin
      errors++;
      $display("[TB] FAIL first_edge10: got %0d, expected 1", cif_a.count);
    end
  endtask

  // Continues from edge 10 after release.
  task automatic test_wrap();
    step(9);
    checks++;
    if (cif_a.count !== 6'd1) begin
      errors++;
      $display("[TB] FAIL wrap_edge19: got %0d, expected 1", cif_a.count);
    end
    step(1);
    checks++;
    if (cif_a.count !== 6'd2) begin
      errors++;
      $display("[TB] FAIL wrap_edge20: got %0d, expected 2", cif_a.count);
    end
    step(609);
    checks++;
    if (cif_a.count !== 6'd62) begin
      errors++;
      $display("[TB] FAIL wrap_edge629: got %0d, expected 62", cif_a.count);
    end
    step(1);
    checks++;
    if (cif_a.count !== 6'd63) begin
      errors++;
      $display("[TB] FAIL wrap_edge630: got %0d, expected 63", cif_a.count);
    end
    step(9);
    checks++;
    if (cif_a.count !== 6'd63) begin
      errors++;
      $display("[TB] FAIL wrap_edge639: got %0d, expected 63", cif_a.count);
    end
    step(1);
    checks++;
    if (cif_a.count !== 6'd0) begin
      errors++;
      $display("[TB] FAIL wrap_edge640: got %0d, expected 0", cif_a.count);
    end
  endtask

  // Continues from edge 640 (count 0, prescaler 0).
  task automatic test_async_reset();
    // Edge 675: count 3, prescaler at 5.
    step(35);
    checks++;
    if (cif_a.count !== 6'd3) begin
      errors++;
      $display("[TB] FAIL midperiod_count: got %0d, expected 3", cif_a.count);
    end
    #5;
    rst_a = 1'b1;
    #1;
    checks++;
    if (cif_a.count !== 6'd0) begin
      errors++;
      $display("[TB] FAIL async_clear: got %0d, expected 0", cif_a.count);
    end
    step(2);
    checks++;
    if (cif_a.count !== 6'd0) begin
      errors++;
      $display("[TB] FAIL async_hold: got %0d, expected 0", cif_a.count);
    end
    @(negedge clk);
    rst_a = 1'b0;
    step(9);
    checks++;
    if (cif_a.count !== 6'd0) begin
      errors++;
      $display("[TB] FAIL rerelease_edge9: got %0d, expected 0", cif_a.count);
    end
    step(1);
    checks++;
    if (cif_a.count !== 6'd1) begin
      errors++;
      $display("[TB] FAIL rerelease_edge10: got %0d, expected 1", cif_a.count);
    end
  endtask

  // DIV=1 instance has been held in reset the whole time so far.
  task automatic test_div1();
    checks++;
    if (cif_b.count !== 6'd0) begin
      errors++;
      $display("[TB] FAIL div1_long_reset: got %0d, expected 0", cif_b.count);
    end
    @(negedge clk);
    rst_b = 1'b0;
    step(1);
    checks++;
    if (cif_b.count !== 6'd1) begin
      errors++;
      $display("[TB] FAIL div1_edge1: got %0d, expected 1", cif_b.count);
    end
    step(1);
    checks++;
    if (cif_b.count !== 6'd2) begin
      errors++;
      $display("[TB] FAIL div1_edge2: got %0d, expected 2", cif_b.count);
    end
    step(61);
    checks++;
    if (cif_b.count !== 6'd63) begin
      errors++;
      $display("[TB] FAIL div1_edge63: got %0d, expected 63", cif_b.count);
    end
    step(1);
    checks++;
    if (cif_b.count !== 6'd0) begin
      errors++;
      $display("[TB] FAIL div1_edge64: got %0d, expected 0", cif_b.count);
    end
    step(1);
    checks++;
    if (cif_b.count !== 6'd1) begin
      errors++;
      $display("[TB] FAIL div1_edge65: got %0d, expected 1", cif_b.count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_increment();
    test_wrap();
    test_async_reset();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
